// File: rtl/usb_fs_ep_rx_packer_pkg.sv
// usb_fs_ep_rx_packer_pkg: handshake codes, transaction-type bit positions and SETUP length shared by the rx packer
package usb_fs_ep_rx_packer_pkg;
  typedef enum logic [1:0] {HS_ACK = 2'd0, HS_NAK = 2'd1, HS_STALL = 2'd2} hs_e;
  localparam int TXN_SETUP = 2;
  localparam int TXN_OUT = 1;
  localparam int TXN_IN = 0;
  localparam int SETUP_NBYTES = 8;
endpackage

// File: rtl/usb_fs_byte_packer.sv
// usb_fs_byte_packer: byte-indexed payload buffer with saturating count and overflow flag
// clk/rst: clock and sync active-high reset; clr: restart a packet; wr/din: incoming payload byte
// data: packed payload (byte n at [8n+7:8n]); n: stored byte count; n_nxt/ovf_nxt: count and overflow including this cycle's byte
module usb_fs_byte_packer #(
  parameter int MAX_PKT = 8,
  parameter int NW = $clog2(MAX_PKT) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr,
  input  logic [7:0]           din,
  output logic [8*MAX_PKT-1:0] data,
  output logic [NW-1:0]        n,
  output logic [NW-1:0]        n_nxt,
  output logic                 ovf_nxt
);
  logic ovf;
  logic room;
  assign room = n < NW'(MAX_PKT);
  assign n_nxt = n + NW'(wr && room);
  assign ovf_nxt = ovf | (wr && !room);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
      n <= '0;
      ovf <= 1'b0;
    end else begin
      n <= n_nxt;
      ovf <= ovf_nxt;
      if (wr && room) data[{n, 3'b000} +: 8] <= din;
    end
  end
endmodule

// File: rtl/usb_fs_ep_rx_packer.sv
// usb_fs_ep_rx_packer: packs SETUP/OUT data packets for an endpoint, tracks DATA0/DATA1 and returns ACK/NAK/STALL
// i_pkt*/i_byte*: receiver packet stream; o_er*/i_er*: endpoint valid/ready payload interface
// o_txnType: latched transaction type; o_hsValid/o_hsPid: one-cycle handshake strobe to the transaction layer
module usb_fs_ep_rx_packer
  import usb_fs_ep_rx_packer_pkg::*;
#(
  parameter int MAX_PKT = 8,
  parameter int NAK_TIMEOUT = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_pktBegin,
  input  logic [2:0]                   i_txnType,
  input  logic                         i_pktData1,
  input  logic                         i_byteValid,
  input  logic [7:0]                   i_byte,
  input  logic                         i_pktEnd,
  input  logic                         i_pktErr,
  output logic                         o_erValid,
  input  logic                         i_erReady,
  input  logic                         i_erStall,
  output logic [8*MAX_PKT-1:0]         o_erData,
  output logic [$clog2(MAX_PKT):0]     o_erData_nBytes,
  output logic [2:0]                   o_txnType,
  output logic                         o_hsValid,
  output logic [1:0]                   o_hsPid
);
  localparam int NW = $clog2(MAX_PKT) + 1;
  localparam int CW = $clog2(NAK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_e;
  state_e state, state_n;
  logic [2:0] txn_n;
  logic pid, pid_n, tog, tog_n, hs_v_n, clr, wr, ovf_nxt, begin_ok, setup;
  logic [1:0] hs_pid_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NW-1:0] n_nxt;
  assign begin_ok = i_txnType == 3'b100 || i_txnType == 3'b010;
  assign setup = o_txnType[TXN_SETUP];
  assign o_erValid = state == PRESENT;
  usb_fs_byte_packer #(.MAX_PKT(MAX_PKT), .NW(NW)) u_packer (
    .clk(i_clk), .rst(i_rst), .clr(clr), .wr(wr), .din(i_byte),
    .data(o_erData), .n(o_erData_nBytes), .n_nxt(n_nxt), .ovf_nxt(ovf_nxt)
  );
  // A new packet start overrides every other event; an IN/invalid start only abandons what is in flight.
  always_comb begin
    state_n = state;
    txn_n = o_txnType;
    pid_n = pid;
    tog_n = tog;
    cnt_n = cnt;
    hs_v_n = 1'b0;
    hs_pid_n = o_hsPid;
    clr = 1'b0;
    wr = 1'b0;
    if (i_pktBegin) begin
      clr = begin_ok;
      state_n = begin_ok ? COLLECT : IDLE;
      txn_n = begin_ok ? i_txnType : o_txnType;
      pid_n = begin_ok ? i_pktData1 : pid;
    end else begin
      case (state)
        COLLECT: begin
          wr = i_byteValid;
          if (i_pktErr) state_n = IDLE;
          else if (i_pktEnd) begin
            state_n = IDLE;
            if (!(ovf_nxt || (setup && n_nxt != NW'(SETUP_NBYTES)))) begin
              tog_n = setup ? 1'b0 : tog;
              // Mismatched PID is a retransmission: re-ACK it, except SETUP/DATA1 which is dropped silently.
              if (pid != (setup ? 1'b0 : tog)) begin
                hs_v_n = !setup;
                hs_pid_n = setup ? o_hsPid : HS_ACK;
              end else begin
                state_n = PRESENT;
                cnt_n = '0;
              end
            end
          end
        end
        PRESENT: begin
          if (i_erReady) begin
            state_n = IDLE;
            hs_v_n = 1'b1;
            hs_pid_n = i_erStall ? HS_STALL : HS_ACK;
            tog_n = i_erStall ? tog : ~tog;
          end else if (!setup && cnt == CW'(NAK_TIMEOUT - 1)) begin
            state_n = IDLE;
            hs_v_n = 1'b1;
            hs_pid_n = HS_NAK;
          end else cnt_n = cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_txnType <= '0;
      pid <= 1'b0;
      tog <= 1'b0;
      cnt <= '0;
      o_hsValid <= 1'b0;
      o_hsPid <= '0;
    end else begin
      state <= state_n;
      o_txnType <= txn_n;
      pid <= pid_n;
      tog <= tog_n;
      cnt <= cnt_n;
      o_hsValid <= hs_v_n;
      o_hsPid <= hs_pid_n;
    end
  end
endmodule

// File: tb/tb_usb_fs_ep_rx_packer.sv
// tb_usb_fs_ep_rx_packer: scoreboard bench for the endpoint rx packer
module tb_usb_fs_ep_rx_packer;
  logic i_clk = 0, i_rst = 1, i_pktBegin = 0, i_pktData1 = 0, i_byteValid = 0, i_pktEnd = 0, i_pktErr = 0;
  logic i_erReady = 0, i_erStall = 0;
  logic [2:0] i_txnType = 0;
  logic [7:0] i_byte = 0;
  logic o_erValid, o_hsValid;
  logic [63:0] o_erData;
  logic [3:0] o_erData_nBytes;
  logic [2:0] o_txnType;
  logic [1:0] o_hsPid;
  typedef struct {logic [63:0] data; logic [3:0] n; logic [2:0] t; int at;} pkt_t;
  typedef struct {logic [1:0] pid; int at;} hs_t;
  pkt_t exp_pkt[$];
  hs_t exp_hs[$];
  int checks = 0, errors = 0, cyc = 0, end_cyc = 0;
  logic pv = 0;
  localparam logic [2:0] SETUP = 3'b100, OUT = 3'b010, IN = 3'b001;
  localparam logic [1:0] ACK = 2'd0, NAK = 2'd1, STALL = 2'd2;

  usb_fs_ep_rx_packer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pktBegin(i_pktBegin), .i_txnType(i_txnType), .i_pktData1(i_pktData1),
    .i_byteValid(i_byteValid), .i_byte(i_byte), .i_pktEnd(i_pktEnd), .i_pktErr(i_pktErr),
    .o_erValid(o_erValid), .i_erReady(i_erReady), .i_erStall(i_erStall), .o_erData(o_erData),
    .o_erData_nBytes(o_erData_nBytes), .o_txnType(o_txnType), .o_hsValid(o_hsValid), .o_hsPid(o_hsPid)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic d1, input int nb, input logic [127:0] b, input int err_at, input bit end_err);
    i_pktBegin = 1; i_txnType = t; i_pktData1 = d1;
    step();
    i_pktBegin = 0; i_txnType = 0; i_pktData1 = 0;
    for (int k = 0; k < nb; k++) begin
      i_byteValid = 1; i_byte = b[8*k +: 8];
      if (k == err_at) i_pktErr = 1;
      if (k == nb - 1 && err_at < 0) begin
        i_pktEnd = 1;
        if (end_err) i_pktErr = 1;
      end
      step();
      i_byteValid = 0; i_byte = 0; i_pktEnd = 0; i_pktErr = 0;
      if (k == err_at) break;
    end
    end_cyc = cyc;
  endtask

  task automatic exp_present(input logic [63:0] d, input logic [3:0] n, input logic [2:0] t, input int at);
    pkt_t p;
    p.data = d; p.n = n; p.t = t; p.at = at;
    exp_pkt.push_back(p);
  endtask

  task automatic exp_hand(input logic [1:0] pid, input int at);
    hs_t h;
    h.pid = pid; h.at = at;
    exp_hs.push_back(h);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, 64'(o_erValid), 0);
    chk({nm, "_data"}, o_erData, 0);
    chk({nm, "_nbytes"}, 64'(o_erData_nBytes), 0);
    chk({nm, "_txn"}, 64'(o_txnType), 0);
    chk({nm, "_hsvalid"}, 64'(o_hsValid), 0);
    chk({nm, "_hspid"}, 64'(o_hsPid), 0);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_erValid && !pv) begin
        if (exp_pkt.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_present: got data %0h n %0d at cycle %0d, required none", o_erData, o_erData_nBytes, cyc);
        end else begin
          pkt_t p;
          p = exp_pkt.pop_front();
          chk("present_data", o_erData, p.data);
          chk("present_nbytes", 64'(o_erData_nBytes), 64'(p.n));
          chk("present_txn", 64'(o_txnType), 64'(p.t));
          chk("present_cycle", 64'(cyc), 64'(p.at));
        end
      end
      if (o_hsValid) begin
        if (exp_hs.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_hs: got pid %0d at cycle %0d, required none", o_hsPid, cyc);
        end else begin
          hs_t h;
          h = exp_hs.pop_front();
          chk("hs_pid", 64'(o_hsPid), 64'(h.pid));
          chk("hs_cycle", 64'(cyc), 64'(h.at));
        end
      end
    end
    pv <= o_erValid;
  end

  initial begin
    repeat (2) step();
    i_rst = 0;
    chk_reset_outputs("reset");
    // OUT DATA0, accepted: ACK, toggle -> 1
    i_erReady = 1;
    send(OUT, 0, 3, 128'h332211, -1, 0);
    exp_present(64'h332211, 3, OUT, end_cyc);
    exp_hand(ACK, end_cyc + 1);
    repeat (3) step();
    // same OUT DATA0 again: retransmission, ACK without presenting
    send(OUT, 0, 3, 128'h332211, -1, 0);
    exp_hand(ACK, end_cyc);
    repeat (3) step();
    // SETUP DATA0 while toggle=1: forced to DATA0 and accepted
    send(SETUP, 0, 8, 128'h0040000001000680, -1, 0);
    exp_present(64'h0040000001000680, 8, SETUP, end_cyc);
    exp_hand(ACK, end_cyc + 1);
    repeat (3) step();
    // OUT DATA1 never accepted: NAK after 16 presented cycles
    i_erReady = 0;
    send(OUT, 1, 2, 128'hBBAA, -1, 0);
    exp_present(64'hBBAA, 2, OUT, end_cyc);
    exp_hand(NAK, end_cyc + 16);
    repeat (20) step();
    // retry with stall
    i_erReady = 1; i_erStall = 1;
    send(OUT, 1, 2, 128'hBBAA, -1, 0);
    exp_present(64'hBBAA, 2, OUT, end_cyc);
    exp_hand(STALL, end_cyc + 1);
    repeat (3) step();
    i_erStall = 0;
    // overflow, mid-packet error, IN, same-cycle end+error: all silent
    send(OUT, 1, 9, 128'h090807060504030201, -1, 0);
    repeat (3) step();
    send(OUT, 1, 4, 128'h44332211, 2, 0);
    repeat (3) step();
    send(IN, 1, 2, 128'h5566, -1, 0);
    repeat (3) step();
    send(OUT, 1, 2, 128'h5566, -1, 1);
    repeat (3) step();
    // toggle still 1: OUT DATA1 is new data, ACK -> toggle 0
    send(OUT, 1, 1, 128'hC3, -1, 0);
    exp_present(64'hC3, 1, OUT, end_cyc);
    exp_hand(ACK, end_cyc + 1);
    repeat (3) step();
    // pktBegin during PRESENT abandons the old packet, even with ready high on that edge
    i_erReady = 0;
    send(OUT, 0, 2, 128'h3412, -1, 0);
    exp_present(64'h3412, 2, OUT, end_cyc);
    repeat (3) step();
    i_erReady = 1;
    send(OUT, 0, 1, 128'h5A, -1, 0);
    exp_present(64'h5A, 1, OUT, end_cyc);
    exp_hand(ACK, end_cyc + 1);
    repeat (3) step();
    // reset during COLLECT (toggle was 1)
    i_pktBegin = 1; i_txnType = OUT; i_pktData1 = 1;
    step();
    i_pktBegin = 0; i_txnType = 0; i_pktData1 = 0;
    i_byteValid = 1; i_byte = 8'h01;
    step();
    i_byte = 8'h02;
    step();
    i_byteValid = 0; i_byte = 0; i_rst = 1;
    step();
    i_rst = 0;
    chk_reset_outputs("midrst");
    // toggle back to 0: DATA1 is a retransmission, DATA0 is presented
    send(OUT, 1, 1, 128'h77, -1, 0);
    exp_hand(ACK, end_cyc);
    repeat (3) step();
    send(OUT, 0, 1, 128'h66, -1, 0);
    exp_present(64'h66, 1, OUT, end_cyc);
    exp_hand(ACK, end_cyc + 1);
    repeat (20) step();
    chk("pending_present", 64'(exp_pkt.size()), 0);
    chk("pending_hs", 64'(exp_hs.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
